f2i_share_arb: RTL and testbench

//  Shares one float-to-integer converter among NREQ requesters, e.g. several

---
 rtl/f2i_share_arb_if.sv | 38 +++
 rtl/f2i_share_arb.sv | 126 ++++++++++++
 tb/tb_f2i_share_arb.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/f2i_share_arb_if.sv
// f2i_share_arb_if
//   Handshake bundle between the requesters/consumer and f2i_share_arb.
//   slave  : the arbiter side (takes requests, produces results)
//   master : the environment side (requesters plus result consumer)
// Signals
//   req_valid [NREQ]    per-requester operand valid
//   req_data  [NREQ*W]  operands, slice i = req_data[i*W +: W]
//   req_ready [NREQ]    one-hot grant/accept strobe
//   out_valid           result valid
//   out_data  [W]       signed integer result
//   out_id    [IW]      requester that owns out_data
//   out_ready           consumer accepts result
interface f2i_share_arb_if #(
    parameter int MAN  = 23,
    parameter int EXP  = 8,
    parameter int NREQ = 4
);
    localparam int W  = MAN + EXP + 1;
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [IW-1:0]     out_id;
    logic              out_ready;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/f2i_share_arb.sv
// f2i_share_arb
//   Shares one float-to-integer converter among NREQ requesters with
//   round-robin arbitration. One operand is captured, converted in a
//   registered stage, and the tagged result is held until accepted.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : f2i_share_arb_if.slave (request valid/data/ready, result
//          valid/data/id/ready)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; grants one combinationally
//   BUSY  | converting the captured operand into out_data/out_id
//   DONE  | result held until out_ready; no grants
module f2i_share_arb #(
    parameter int MAN  = 23,
    parameter int EXP  = 8,
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    f2i_share_arb_if.slave  bus
);
    localparam int W  = MAN + EXP + 1;
    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [IW-1:0]   ptr;
    logic [W-1:0]    op;
    logic [IW-1:0]   op_id;
    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [IW-1:0]   out_id_q;

    // Round-robin search starting just after the last grant.
    logic            found;
    logic [IW-1:0]   gnt;
    logic [NREQ-1:0] ready_vec;

    always_comb begin
        int tmp;
        logic [IW-1:0] cand;
        found = 1'b0;
        gnt   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            tmp = int'(ptr) + k;
            if (tmp >= NREQ) tmp = tmp - NREQ;
            cand = IW'(tmp);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
        ready_vec = '0;
        if (!rst && state == S_IDLE && found) ready_vec[gnt] = 1'b1;
    end

    assign bus.req_ready = ready_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

    // Conversion of the captured word. The right-shift amount needs EXP+1
    // bits so that e = 100..0 becomes a shift of 2^(EXP-1).
    logic                cv_s;
    logic [EXP-1:0]      cv_e;
    logic [MAN-1:0]      cv_m;
    logic [MAN:0]        mag;
    logic [MAN:0]        sm;
    logic signed [W-1:0] smx;
    logic [EXP:0]        rsh;
    logic [W-1:0]        conv;

    always_comb begin
        cv_s = op[W-1];
        cv_e = op[W-2:MAN];
        cv_m = op[MAN-1:0];
        mag  = {1'b0, cv_m};
        sm   = cv_s ? -mag : mag;
        smx  = {{EXP{sm[MAN]}}, sm};
        rsh  = {1'b0, ~cv_e} + {{EXP{1'b0}}, 1'b1};
        if (cv_e[EXP-1]) conv = smx >>> rsh;
        else             conv = smx << cv_e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= IW'(NREQ - 1);
            op          <= '0;
            op_id       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        op    <= bus.req_data[gnt*W +: W];
                        op_id <= gnt;
                        ptr   <= gnt;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    out_data_q  <= conv;
                    out_id_q    <= op_id;
                    out_valid_q <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_f2i_share_arb.sv
module tb_f2i_share_arb;
    localparam int MAN  = 23;
    localparam int EXP  = 8;
    localparam int NREQ = 4;

    logic clk;
    logic rst;

    f2i_share_arb_if #(.MAN(MAN), .EXP(EXP), .NREQ(NREQ)) bus ();

    f2i_share_arb #(.MAN(MAN), .EXP(EXP), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          idx;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One isolated transaction from IDLE back to IDLE, consumer always ready.
    task automatic txn(input int idx, input logic [31:0] din, input logic [31:0] dout);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        bus.req_data[idx*32 +: 32] = din;
        bus.req_valid = oh;
        bus.out_ready = 1'b1;
        #1;
        chk("grant", 32'(bus.req_ready), 32'(oh));
        tick();
        bus.req_valid = 4'b0000;
        #1;
        chk("busy_valid", 32'(bus.out_valid), 32'd0);
        chk("busy_ready", 32'(bus.req_ready), 32'd0);
        tick();
        chk("done_valid", 32'(bus.out_valid), 32'd1);
        chk("done_data", bus.out_data, dout);
        chk("done_id", 32'(bus.out_id), 32'(idx));
        tick();
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [3:0] oh;
        int e;

        vecs[0] = '{0, 32'h01000005, 32'h00000014};
        vecs[1] = '{2, 32'h81000005, 32'hFFFFFFEC};
        vecs[2] = '{1, 32'hFF800003, 32'hFFFFFFFE};
        vecs[3] = '{3, 32'h7F000001, 32'h00000000};
        vecs[4] = '{0, 32'hC0000007, 32'hFFFFFFFF};
        vecs[5] = '{1, 32'h80000000, 32'h00000000};
        vecs[6] = '{2, 32'h0F800001, 32'h80000000};
        vecs[7] = '{3, 32'hFF800001, 32'hFFFFFFFF};
        vecs[8] = '{0, 32'h00000007, 32'h00000007};
        vecs[9] = '{1, 32'h8A000001, 32'hFFF00000};

        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        tick();
        bus.req_valid = 4'b1111;
        tick();
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_id", 32'(bus.out_id), 32'd0);
        bus.req_valid = 4'b0000;
        rst = 1'b0;
        tick();

        // Conversion vectors
        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].idx, vecs[i].din, vecs[i].dout);
        end

        // All requesters held valid from reset: grants 0,1,2,3,0, 3 cycles apart
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = 32'h00800000 | 32'(i + 1);
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            e  = g % 4;
            oh = 4'b0001 << e;
            chk("rr_grant", 32'(bus.req_ready), 32'(oh));
            tick();
            chk("rr_busy_ready", 32'(bus.req_ready), 32'd0);
            tick();
            chk("rr_valid", 32'(bus.out_valid), 32'd1);
            chk("rr_id", 32'(bus.out_id), 32'(e));
            chk("rr_data", bus.out_data, 32'(2 * (e + 1)));
            if (g == 4) bus.req_valid = 4'b0000;
            tick();
        end

        // Back-pressure in DONE
        for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = 32'h01000005;
        bus.req_valid = 4'b0010;
        #1;
        chk("bp_grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_data", bus.out_data, 32'h14);
            chk("bp_id", 32'(bus.out_id), 32'd1);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("hs_ready", 32'(bus.req_ready), 32'd0);
        chk("hs_valid", 32'(bus.out_valid), 32'd1);
        tick();
        chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
        chk("post_hs_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        chk("post_hs_id", 32'(bus.out_id), 32'd2);
        chk("post_hs_data", bus.out_data, 32'h14);
        tick();

        // Reset during BUSY, then req0 served before req3
        bus.req_data[0 +: 32] = 32'h00000007;
        bus.req_valid = 4'b0001;
        #1;
        chk("mr_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0000;
        rst = 1'b1;
        #1;
        chk("mr_rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_id", 32'(bus.out_id), 32'd0);
        chk("mr_data", bus.out_data, 32'd0);
        bus.req_data[0 +: 32]  = 32'h01000005;
        bus.req_data[96 +: 32] = 32'h81000005;
        bus.req_valid = 4'b1001;
        #1;
        chk("mr_first", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b1000;
        tick();
        chk("mr_id0", 32'(bus.out_id), 32'd0);
        chk("mr_data0", bus.out_data, 32'h14);
        tick();
        chk("mr_second", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        chk("mr_id3", 32'(bus.out_id), 32'd3);
        chk("mr_data3", bus.out_data, 32'hFFFFFFEC);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
